// File: rtl/case_3_accum_pkg.sv
// Shared types and helpers for the case_3 product accumulator.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package case_3_accum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest value representable in a w-bit two's complement number.
  function automatic logic signed [63:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's complement number.
  function automatic logic signed [63:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/case_3_sat_add.sv
// Saturating signed add: acc + sign-extended din, clipped to the acc range.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module case_3_sat_add
  import case_3_accum_pkg::*;
#(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 20
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [DIN_WIDTH-1:0] din,
  output logic signed [ACC_WIDTH-1:0] sum,
  output logic                        sat
);

  localparam logic signed [63:0] MAX64 = acc_max(ACC_WIDTH);
  localparam logic signed [63:0] MIN64 = acc_min(ACC_WIDTH);

  // One extra bit holds any acc + din sum exactly, so the clip decision is exact.
  logic signed [ACC_WIDTH:0] w_wide;
  logic signed [63:0]        w_wide64;

  assign w_wide   = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(din);
  assign w_wide64 = 64'(w_wide);

  // Clip the exact sum into range and flag when clipping happened.
  always_comb begin
    sum = w_wide[ACC_WIDTH-1:0];
    sat = 1'b0;
    if (w_wide64 > MAX64) begin
      sum = MAX64[ACC_WIDTH-1:0];
      sat = 1'b1;
    end else if (w_wide64 < MIN64) begin
      sum = MIN64[ACC_WIDTH-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/case_3_prod_accum.sv
// Accumulates a frame of len signed products into a saturating sum with ap_* control.
// Latency: acc_vld rises 1 cycle after the last transfer (1 cycle after start if len==0).
// Backpressure: prod_rdy only in ACCUM; result held in DONE until acc_ack, no new start meanwhile.
module case_3_prod_accum
  import case_3_accum_pkg::*;
#(
  parameter int DIN_WIDTH = 10,
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 8
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        ap_start,
  output logic                        ap_ready,
  output logic                        ap_idle,
  output logic                        ap_done,
  input  logic [LEN_WIDTH-1:0]        len,
  input  logic signed [DIN_WIDTH-1:0] prod_din,
  input  logic                        prod_vld,
  output logic                        prod_rdy,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        acc_vld,
  input  logic                        acc_ack,
  output logic                        acc_ovf
);

  state_t                      r_state;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_acc_out;
  logic [LEN_WIDTH-1:0]        r_cnt;
  logic [LEN_WIDTH-1:0]        r_len;
  logic                        r_acc_vld;
  logic                        r_acc_ovf;

  logic signed [ACC_WIDTH-1:0] w_sum;
  logic                        w_sat;
  logic                        w_last;

  case_3_sat_add #(
    .DIN_WIDTH (DIN_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_add (
    .acc (r_acc),
    .din (prod_din),
    .sum (w_sum),
    .sat (w_sat)
  );

  // The transfer that brings the count up to len_r closes the frame.
  assign w_last = (r_cnt == (r_len - LEN_WIDTH'(1)));

  assign ap_ready = ap_start && (r_state == IDLE);
  assign ap_idle  = (r_state == IDLE);
  assign prod_rdy = (r_state == ACCUM);
  assign ap_done  = r_acc_vld;
  assign acc_vld  = r_acc_vld;
  assign acc_out  = r_acc_out;
  assign acc_ovf  = r_acc_ovf;

  // Frame sequencer: capture on start, accumulate per transfer, hold result until ack.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_acc_out <= '0;
      r_cnt     <= '0;
      r_len     <= '0;
      r_acc_vld <= 1'b0;
      r_acc_ovf <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ap_start) begin
            r_len     <= len;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_acc_ovf <= 1'b0;
            if (len == '0) begin
              // Empty frame: report a zero sum without ever asking for products.
              r_acc_out <= '0;
              r_acc_vld <= 1'b1;
              r_state   <= DONE;
            end else begin
              r_state   <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (prod_vld) begin
            r_acc     <= w_sum;
            r_cnt     <= r_cnt + LEN_WIDTH'(1);
            r_acc_ovf <= r_acc_ovf | w_sat;
            if (w_last) begin
              r_acc_out <= w_sum;
              r_acc_vld <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          if (acc_ack) begin
            r_acc_vld <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_3_prod_accum.sv
// Scoreboard bench for the product accumulator, run with a 12-bit accumulator.
// Latency: n/a.
// Backpressure: n/a.
module tb_case_3_prod_accum;

  localparam int DW   = 10;
  localparam int AW   = 12;
  localparam int LW   = 8;
  localparam int AMAX = (1 << (AW - 1)) - 1;
  localparam int AMIN = -(1 << (AW - 1));

  logic                 ap_clk   = 1'b0;
  logic                 ap_rst_n = 1'b0;
  logic                 ap_start = 1'b0;
  logic                 ap_ready;
  logic                 ap_idle;
  logic                 ap_done;
  logic [LW-1:0]        len      = '0;
  logic signed [DW-1:0] prod_din = '0;
  logic                 prod_vld = 1'b0;
  logic                 prod_rdy;
  logic signed [AW-1:0] acc_out;
  logic                 acc_vld;
  logic                 acc_ack  = 1'b0;
  logic                 acc_ovf;

  always #5 ap_clk = ~ap_clk;

  case_3_prod_accum #(
    .DIN_WIDTH (DW),
    .ACC_WIDTH (AW),
    .LEN_WIDTH (LW)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .len      (len),
    .prod_din (prod_din),
    .prod_vld (prod_vld),
    .prod_rdy (prod_rdy),
    .acc_out  (acc_out),
    .acc_vld  (acc_vld),
    .acc_ack  (acc_ack),
    .acc_ovf  (acc_ovf)
  );

  typedef struct {
    int sum;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   din_q[$];
  int   gap_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference: plain integer running sum, clipped after every addition.
  task automatic model_frame(input int n, output exp_t e);
    int s;
    int o;
    s = 0;
    o = 0;
    for (int i = 0; i < n; i++) begin
      s = s + din_q[i];
      if (s > AMAX) begin s = AMAX; o = 1; end
      if (s < AMIN) begin s = AMIN; o = 1; end
    end
    e.sum = s;
    e.ovf = o;
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Monitor: pop on each new result, and require acc_out to hold at all other times.
  logic                 prev_vld = 1'b0;
  logic signed [AW-1:0] held_out = '0;
  exp_t                 mon_e;
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_vld = 1'b0;
      held_out = '0;
    end else begin
      if (acc_vld && !prev_vld) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("acc_out", int'(acc_out), mon_e.sum);
          check("acc_ovf", int'(acc_ovf), mon_e.ovf);
        end
        held_out = acc_out;
      end else begin
        check("acc_out_hold", int'(acc_out), int'(held_out));
      end
      if (acc_vld) begin
        check("ap_done_level", int'(ap_done), 1);
        check("ap_ready_in_done", int'(ap_ready), 0);
      end
      prev_vld = acc_vld;
    end
  end

  // Drive one frame from din_q/gap_q; caller sits 1 time unit after a rising edge.
  task automatic run_frame(input int n, input int ack_delay, input bit hold_start);
    exp_t e;
    model_frame(n, e);
    exp_q.push_back(e);
    ap_start = 1'b1;
    len      = LW'(n);
    @(negedge ap_clk);
    check("ap_ready_on_start", int'(ap_ready), 1);
    check("prod_rdy_idle", int'(prod_rdy), 0);
    tick();
    ap_start = 1'b0;
    len      = LW'($urandom);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap_q[i]; g++) begin
        prod_vld = 1'b0;
        prod_din = DW'($urandom);
        tick();
      end
      prod_vld = 1'b1;
      prod_din = DW'(din_q[i]);
      @(negedge ap_clk);
      check("prod_rdy_accum", int'(prod_rdy), 1);
      check("no_early_vld", int'(acc_vld), 0);
      tick();
    end
    prod_vld = 1'b0;
    @(negedge ap_clk);
    check("acc_vld_latency", int'(acc_vld), 1);
    check("prod_rdy_done", int'(prod_rdy), 0);
    tick();
    if (hold_start) begin
      ap_start = 1'b1;
      len      = '0;
    end
    for (int k = 0; k < ack_delay; k++) tick();
    acc_ack = 1'b1;
    if (hold_start) exp_q.push_back('{0, 0});
    tick();
    acc_ack = 1'b0;
    @(negedge ap_clk);
    check("idle_after_ack", int'(ap_idle), 1);
    check("ap_ready_after_ack", int'(ap_ready), hold_start ? 1 : 0);
    if (!hold_start) check("vld_low_after_ack", int'(acc_vld), 0);
    tick();
    if (hold_start) begin
      ap_start = 1'b0;
      @(negedge ap_clk);
      check("zero_frame_vld", int'(acc_vld), 1);
      tick();
      acc_ack = 1'b1;
      tick();
      acc_ack = 1'b0;
      tick();
    end
  endtask

  task automatic set_frame(input int n, input int d, input bit rnd);
    din_q.delete();
    gap_q.delete();
    for (int i = 0; i < n; i++) begin
      din_q.push_back(rnd ? (int'($urandom_range(1023)) - 512) : d);
      gap_q.push_back(rnd ? int'($urandom_range(2)) : 0);
    end
  endtask

  task automatic check_reset_values();
    check("rst_acc_vld", int'(acc_vld), 0);
    check("rst_ap_done", int'(ap_done), 0);
    check("rst_acc_out", int'(acc_out), 0);
    check("rst_acc_ovf", int'(acc_ovf), 0);
    check("rst_prod_rdy", int'(prod_rdy), 0);
    check("rst_ap_idle", int'(ap_idle), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge ap_clk);
    #1;
    check_reset_values();
    ap_rst_n = 1'b1;
    tick();

    // Basic frame: 3 - 5 + 100 - 511 = -413.
    din_q = '{3, -5, 100, -511};
    gap_q = '{0, 0, 0, 0};
    run_frame(4, 3, 1'b0);

    // Empty frame.
    din_q.delete();
    gap_q.delete();
    run_frame(0, 1, 1'b0);

    // Input gaps: vld pattern 1,0,0,1,0,1.
    din_q = '{1, 2, 3};
    gap_q = '{0, 2, 1};
    run_frame(3, 0, 1'b0);

    // Saturation both ways, then a clean frame clears the overflow flag.
    set_frame(5, 511, 1'b0);
    run_frame(5, 0, 1'b0);
    set_frame(5, -512, 1'b0);
    run_frame(5, 2, 1'b0);
    set_frame(1, 1, 1'b0);
    run_frame(1, 0, 1'b0);

    // Reset two transfers into a four-product frame.
    ap_start = 1'b1;
    len      = LW'(4);
    tick();
    ap_start = 1'b0;
    prod_vld = 1'b1;
    prod_din = DW'(50);
    tick();
    prod_din = DW'(60);
    tick();
    prod_vld = 1'b0;
    #2;
    ap_rst_n = 1'b0;
    #1;
    check_reset_values();
    tick();
    ap_rst_n = 1'b1;
    tick();
    din_q = '{7, 8};
    gap_q = '{0, 0};
    run_frame(2, 0, 1'b0);

    // Output stall with ap_start held, followed by an immediately accepted empty frame.
    din_q = '{5, 6};
    gap_q = '{1, 0};
    run_frame(2, 10, 1'b1);

    // Randomized frames, some long enough to saturate.
    for (int f = 0; f < 30; f++) begin
      int n;
      n = int'($urandom_range(12));
      set_frame(n, 0, 1'b1);
      if (f % 5 == 4) begin
        for (int i = 0; i < n; i++) din_q[i] = (f % 10 == 4) ? 500 - int'($urandom_range(20)) : -500 + int'($urandom_range(20));
      end
      run_frame(n, int'($urandom_range(3)), 1'b0);
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
